// File: rtl/pmem_line_responder.sv
// pmem_line_responder: line-granular memory responder for the L1 cache pmem_* port.
// It accepts one whole-line read or write, waits LATENCY cycles, then pulses pmem_resp
// for a single cycle. Read data comes from a small register-based line store.
module pmem_line_responder #(
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_BITS  = 256,
  parameter int INDEX_BITS = 4,
  parameter int LATENCY    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [ADDR_WIDTH-1:0] pmem_address,
  input  logic [LINE_BITS-1:0]  pmem_wdata,
  output logic                  pmem_resp,
  output logic [LINE_BITS-1:0]  pmem_rdata,
  output logic                  busy,
  output logic                  proto_err,
  output logic [15:0]           read_count,
  output logic [15:0]           write_count
);

  localparam int         DEPTH = 1 << INDEX_BITS;
  localparam logic [7:0] LAT8  = 8'(LATENCY);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [7:0]              cnt_q, cnt_d;
  logic                    is_wr_q, is_wr_d;
  logic [INDEX_BITS-1:0]   idx_q, idx_d;
  logic [LINE_BITS-1:0]    wdata_q, wdata_d;
  logic [LINE_BITS-1:0]    rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [15:0]             rcnt_q, rcnt_d;
  logic [15:0]             wcnt_q, wcnt_d;
  logic [LINE_BITS-1:0]    store_q [DEPTH];
  logic [LINE_BITS-1:0]    store_d [DEPTH];

  logic                    req;
  logic [INDEX_BITS-1:0]   req_idx;
  logic                    unused_addr_bits;

  assign req              = pmem_read | pmem_write;
  assign req_idx          = pmem_address[5 +: INDEX_BITS];
  // The byte offset and upper address bits do not select a line. Upper bits alias.
  assign unused_addr_bits = ^{pmem_address[ADDR_WIDTH-1:5+INDEX_BITS], pmem_address[4:0]};

  assign pmem_resp   = (state_q == S_RESP);
  assign busy        = (state_q != S_IDLE);
  assign pmem_rdata  = rdata_q;
  assign proto_err   = err_q;
  assign read_count  = rcnt_q;
  assign write_count = wcnt_q;

  // Next-state logic: accept, count down, respond, commit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    is_wr_d = is_wr_q;
    idx_d   = idx_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    rcnt_d  = rcnt_q;
    wcnt_d  = wcnt_q;
    for (int i = 0; i < DEPTH; i++) store_d[i] = store_q[i];

    unique case (state_q)
      S_IDLE: begin
        if (req) begin
          state_d = S_WAIT;
          cnt_d   = LAT8;
          is_wr_d = pmem_write;
          idx_d   = req_idx;
          wdata_d = pmem_wdata;
          if (pmem_read && pmem_write) err_d = 1'b1;
        end
      end
      S_WAIT: begin
        // A request that drops early still completes. The drop is flagged.
        if (!req) err_d = 1'b1;
        if (cnt_q == 8'd1) begin
          state_d = S_RESP;
          if (!is_wr_q) rdata_d = store_q[idx_q];
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        if (is_wr_q) begin
          store_d[idx_q] = wdata_q;
          if (wcnt_q != 16'hFFFF) wcnt_d = wcnt_q + 16'd1;
        end else begin
          if (rcnt_q != 16'hFFFF) rcnt_d = rcnt_q + 16'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers. Reset clears everything and drops any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      is_wr_q <= 1'b0;
      idx_q   <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      rcnt_q  <= '0;
      wcnt_q  <= '0;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      is_wr_q <= is_wr_d;
      idx_q   <= idx_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      rcnt_q  <= rcnt_d;
      wcnt_q  <= wcnt_d;
      for (int i = 0; i < DEPTH; i++) store_q[i] <= store_d[i];
    end
  end

endmodule

// File: tb/tb_pmem_line_responder.sv
// Testbench for pmem_line_responder. It compares the DUT against a line-array
// memory model with transaction-level timing expectations.
module tb_pmem_line_responder;

  localparam int LATENCY = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pmem_read = 1'b0;
  logic         pmem_write = 1'b0;
  logic [31:0]  pmem_address = '0;
  logic [255:0] pmem_wdata = '0;
  logic         pmem_resp;
  logic [255:0] pmem_rdata;
  logic         busy;
  logic         proto_err;
  logic [15:0]  read_count;
  logic [15:0]  write_count;

  int checks = 0;
  int errors = 0;

  // Reference model
  logic [255:0] mem [16];
  int           exp_rc, exp_wc;
  logic         exp_err;
  logic [255:0] exp_rdata;

  pmem_line_responder #(
    .ADDR_WIDTH(32), .LINE_BITS(256), .INDEX_BITS(4), .LATENCY(LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .busy(busy), .proto_err(proto_err),
    .read_count(read_count), .write_count(write_count)
  );

  always #5 clk = ~clk;

  function automatic logic [255:0] rand_line();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mem[i] = '0;
    exp_rc = 0; exp_wc = 0; exp_err = 1'b0; exp_rdata = '0;
  endtask

  task automatic check_quiet(input string name);
    checks++;
    if (pmem_resp !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle: resp=%b busy=%b required 0/0", name, pmem_resp, busy);
    end
    checks++;
    if (read_count !== 16'(exp_rc) || write_count !== 16'(exp_wc)) begin
      errors++;
      $display("FAIL %s counts: rd=%0d wr=%0d required %0d/%0d", name, read_count, write_count, exp_rc, exp_wc);
    end
  endtask

  // A transaction starts in the cycle after the previous RESP, or in any idle cycle,
  // and ends at the negedge of its own RESP cycle.
  task automatic do_txn(input string name, input bit wr, input bit both,
                        input logic [31:0] addr, input logic [255:0] data, input int drop_at);
    int idx;
    bit eff_wr;
    @(posedge clk); @(negedge clk);
    check_quiet(name);
    idx    = int'(addr[8:5]);
    eff_wr = wr || both;
    pmem_address = addr;
    pmem_wdata   = data;
    pmem_read    = !wr || both;
    pmem_write   = wr || both;
    for (int n = 1; n <= LATENCY + 1; n++) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (pmem_resp !== (n == LATENCY + 1)) begin
        errors++;
        $display("FAIL %s resp@+%0d: got %b required %b", name, n, pmem_resp, (n == LATENCY + 1));
      end
      checks++;
      if (busy !== 1'b1) begin
        errors++;
        $display("FAIL %s busy@+%0d: got %b required 1", name, n, busy);
      end
      if (n <= LATENCY) begin
        // The responder must ignore address and data changes in WAIT.
        pmem_address = $urandom;
        pmem_wdata   = rand_line();
        if (n == drop_at) begin
          pmem_read  = 1'b0;
          pmem_write = 1'b0;
          exp_err    = 1'b1;
        end
      end
    end
    if (both) exp_err = 1'b1;
    if (!eff_wr) exp_rdata = mem[idx];
    checks++;
    if (pmem_rdata !== exp_rdata) begin
      errors++;
      $display("FAIL %s rdata: got %h required %h", name, pmem_rdata, exp_rdata);
    end
    checks++;
    if (proto_err !== exp_err) begin
      errors++;
      $display("FAIL %s proto_err: got %b required %b", name, proto_err, exp_err);
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    if (eff_wr) begin
      mem[idx] = data;
      if (exp_wc < 65535) exp_wc++;
    end else begin
      if (exp_rc < 65535) exp_rc++;
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (pmem_resp !== 0 || busy !== 0 || proto_err !== 0 || pmem_rdata !== '0 ||
        read_count !== 0 || write_count !== 0) begin
      errors++;
      $display("FAIL reset outputs: resp=%b busy=%b err=%b rdata=%h rc=%0d wc=%0d required all 0",
               pmem_resp, busy, proto_err, pmem_rdata, read_count, write_count);
    end
    rst = 1'b0;
    model_reset();
    repeat (5) @(negedge clk);
    check_quiet("after_reset");
  endtask

  task automatic test_basic_read();
    do_txn("basic_read", 1'b0, 1'b0, 32'h0000_0040, '0, 0);
  endtask

  task automatic test_back_to_back();
    do_txn("b2b_write", 1'b1, 1'b0, 32'h0000_0060, {8{32'hDEADBEEF}}, 0);
    do_txn("b2b_read",  1'b0, 1'b0, 32'h0000_0060, '0, 0);
    @(posedge clk); @(negedge clk);
    check_quiet("b2b_counts");
  endtask

  task automatic test_alias();
    logic [255:0] a;
    a = rand_line();
    do_txn("alias_write", 1'b1, 1'b0, 32'h0000_0020, a, 0);
    do_txn("alias_read",  1'b0, 1'b0, 32'h0000_0220, '0, 0);
    checks++;
    if (pmem_rdata !== a) begin
      errors++;
      $display("FAIL alias data: got %h required %h", pmem_rdata, a);
    end
  endtask

  task automatic test_both_high();
    logic [255:0] b;
    b = rand_line();
    do_txn("both_high", 1'b0, 1'b1, 32'h0000_00A0, b, 0);
    do_txn("both_readback", 1'b0, 1'b0, 32'h0000_00A0, '0, 0);
    do_txn("both_clean", 1'b1, 1'b0, 32'h0000_0180, rand_line(), 0);
  endtask

  task automatic test_drop();
    do_txn("drop_read", 1'b0, 1'b0, 32'h0000_00A0, '0, 2);
    do_txn("drop_write", 1'b1, 1'b0, 32'h0000_01C0, rand_line(), LATENCY);
  endtask

  task automatic test_reset_mid_wait();
    @(posedge clk); @(negedge clk);
    pmem_address = 32'h0000_0060;
    pmem_wdata   = rand_line();
    pmem_write   = 1'b1;
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    #1;
    checks++;
    if (pmem_resp !== 0 || busy !== 0 || proto_err !== 0 || pmem_rdata !== '0 ||
        read_count !== 0 || write_count !== 0) begin
      errors++;
      $display("FAIL midwait_reset outputs: resp=%b busy=%b err=%b rdata=%h rc=%0d wc=%0d required all 0",
               pmem_resp, busy, proto_err, pmem_rdata, read_count, write_count);
    end
    pmem_write = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (LATENCY + 2) begin
      @(posedge clk); @(negedge clk);
      checks++;
      if (pmem_resp !== 1'b0) begin
        errors++;
        $display("FAIL midwait_no_resp: got %b required 0", pmem_resp);
      end
    end
    do_txn("midwait_readback", 1'b0, 1'b0, 32'h0000_0060, '0, 0);
  endtask

  task automatic test_random();
    for (int t = 0; t < 40; t++) begin
      bit          wr, both;
      int          drop;
      logic [31:0] addr;
      wr   = $urandom_range(0, 1) == 1;
      both = $urandom_range(0, 9) == 0;
      drop = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, LATENCY)) : 0;
      addr = $urandom;
      do_txn("random", wr, both, addr, rand_line(), drop);
    end
    @(posedge clk); @(negedge clk);
    check_quiet("random_final");
  endtask

  initial begin
    model_reset();
    test_reset();
    test_basic_read();
    test_back_to_back();
    test_alias();
    test_both_high();
    test_drop();
    test_reset_mid_wait();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
